// File: rtl/dcache_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dcache_axi_bridge
// Purpose  : Converts dcache line refills and dirty-line writebacks into
//            AXI4 INCR bursts of 32-bit beats, with a same-line read guard.
// Revision : 1.0  initial release
// ============================================================================
module dcache_axi_bridge #(
    parameter int LINE_WORDS = 8,
    parameter int OFFSET_W   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    // dcache read side
    input  logic                     rd_req,
    input  logic [2:0]               rd_type,
    input  logic [31:0]              rd_addr,
    output logic                     rd_rdy,
    output logic                     ret_valid,
    output logic [32*LINE_WORDS-1:0] ret_data,
    // dcache write side
    input  logic                     wr_req,
    input  logic [31:0]              wr_addr,
    input  logic [3:0]               wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                     wr_rdy,
    // AXI read
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [31:0]              rdata,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    // AXI write
    output logic [31:0]              awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam logic [31:0]      c_LINE_MASK = ~((32'd1 << OFFSET_W) - 32'd1);
    localparam logic [7:0]       c_LINE_LEN  = 8'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    localparam logic [1:0] c_R_IDLE = 2'd0;
    localparam logic [1:0] c_R_AR   = 2'd1;
    localparam logic [1:0] c_R_DATA = 2'd2;
    localparam logic [1:0] c_R_RET  = 2'd3;

    localparam logic [1:0] c_W_IDLE = 2'd0;
    localparam logic [1:0] c_W_AW   = 2'd1;
    localparam logic [1:0] c_W_DATA = 2'd2;
    localparam logic [1:0] c_W_B    = 2'd3;

    logic [1:0]       r_rd_state, w_rd_state_nxt;
    logic [1:0]       r_wr_state, w_wr_state_nxt;
    logic [31:0]      r_araddr;
    logic [7:0]       r_arlen;
    logic [2:0]       r_arsize;
    logic [CNT_W-1:0] r_rcnt;
    logic [LINE_W-1:0] r_ret_data;
    logic [31:0]      r_awaddr;
    logic [7:0]       r_awlen;
    logic [2:0]       r_awsize;
    logic [LINE_W-1:0] r_wbuf;
    logic [3:0]       r_wstrb;
    logic [CNT_W-1:0] r_wcnt;

    logic w_hazard;
    logic w_rd_accept;
    logic w_r_beat;
    logic w_wr_accept;
    logic w_w_hs;

    // The incoming wr_addr is checked too, so a same-cycle same-line pair
    // lets the writeback go first.
    always_comb begin
        if (r_wr_state != c_W_IDLE)
            w_hazard = (rd_addr[31:OFFSET_W] == r_awaddr[31:OFFSET_W]);
        else
            w_hazard = wr_req && (rd_addr[31:OFFSET_W] == wr_addr[31:OFFSET_W]);
    end

    assign w_rd_accept = (r_rd_state == c_R_IDLE) && rd_req && !w_hazard;
    assign w_r_beat    = (r_rd_state == c_R_DATA) && rvalid;
    assign w_wr_accept = (r_wr_state == c_W_IDLE) && wr_req;
    assign w_w_hs      = (r_wr_state == c_W_DATA) && wready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_state <= c_R_IDLE;
            r_wr_state <= c_W_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_wr_state <= w_wr_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        rd_rdy    = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        ret_valid = 1'b0;
        case (r_rd_state)
            c_R_IDLE: begin
                rd_rdy = 1'b1;
                if (rd_req && !w_hazard) w_rd_state_nxt = c_R_AR;
            end
            c_R_AR: begin
                arvalid = 1'b1;
                if (arready) w_rd_state_nxt = c_R_DATA;
            end
            c_R_DATA: begin
                rready = 1'b1;
                if (rvalid && (rlast || (8'(r_rcnt) == r_arlen)))
                    w_rd_state_nxt = c_R_RET;
            end
            c_R_RET: begin
                ret_valid      = 1'b1;
                w_rd_state_nxt = c_R_IDLE;
            end
            default: w_rd_state_nxt = c_R_IDLE;
        endcase
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        wr_rdy  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (r_wr_state)
            c_W_IDLE: begin
                wr_rdy = 1'b1;
                if (wr_req) w_wr_state_nxt = c_W_AW;
            end
            c_W_AW: begin
                awvalid = 1'b1;
                if (awready) w_wr_state_nxt = c_W_DATA;
            end
            c_W_DATA: begin
                wvalid = 1'b1;
                if (wready && (r_wcnt == c_LAST_BEAT)) w_wr_state_nxt = c_W_B;
            end
            c_W_B: begin
                bready = 1'b1;
                if (bvalid) w_wr_state_nxt = c_W_IDLE;
            end
            default: w_wr_state_nxt = c_W_IDLE;
        endcase
    end

    // Refill buffer is cleared on acceptance so single reads return zeros above word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arsize   <= '0;
            r_rcnt     <= '0;
            r_ret_data <= '0;
        end else begin
            if (w_rd_accept) begin
                r_ret_data <= '0;
                r_rcnt     <= '0;
                if (rd_type == 3'b100) begin
                    r_araddr <= rd_addr & c_LINE_MASK;
                    r_arlen  <= c_LINE_LEN;
                    r_arsize <= 3'd2;
                end else begin
                    r_araddr <= rd_addr;
                    r_arlen  <= 8'd0;
                    r_arsize <= {1'b0, rd_type[1:0]};
                end
            end
            if (w_r_beat) begin
                r_ret_data[{r_rcnt, 5'd0} +: 32] <= rdata;
                r_rcnt <= r_rcnt + CNT_W'(1);
            end
            if (r_rd_state == c_R_RET) r_rcnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_awaddr <= '0;
            r_awlen  <= '0;
            r_awsize <= '0;
            r_wbuf   <= '0;
            r_wstrb  <= '0;
            r_wcnt   <= '0;
        end else begin
            if (w_wr_accept) begin
                r_awaddr <= wr_addr & c_LINE_MASK;
                r_awlen  <= c_LINE_LEN;
                r_awsize <= 3'd2;
                r_wbuf   <= wr_data;
                r_wstrb  <= wr_wstrb;
                r_wcnt   <= '0;
            end
            if (w_w_hs) r_wcnt <= r_wcnt + CNT_W'(1);
        end
    end

    assign araddr   = r_araddr;
    assign arlen    = r_arlen;
    assign arsize   = r_arsize;
    assign ret_data = r_ret_data;
    assign awaddr   = r_awaddr;
    assign awlen    = r_awlen;
    assign awsize   = r_awsize;
    assign wdata    = r_wbuf[{r_wcnt, 5'd0} +: 32];
    assign wstrb    = r_wstrb;
    assign wlast    = (r_wr_state == c_W_DATA) && (r_wcnt == c_LAST_BEAT);

endmodule
`default_nettype wire
